bp_nonsynth_mem_if_tracker: RTL and testbench

//  Nonsynth runtime monitor, downstream of the static BP interface-width check. It

---
 rtl/bp_nonsynth_mem_if_tracker.sv | 154 +++++++++++++++
 tb/tb_bp_nonsynth_mem_if_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_nonsynth_mem_if_tracker.sv
// Passive simulation monitor for the CCE<->memory command/response channel.
// Tracks outstanding commands in order and raises sticky error flags on misuse.
module bp_nonsynth_mem_if_tracker #(
  parameter int paddr_width_p      = 40,
  parameter int cce_block_width_p  = 64,
  parameter int max_outstanding_p  = 8,
  parameter int timeout_cycles_p   = 4096,
  parameter bit report_p           = 1'b1,
  localparam int msg_type_width_lp    = 4,
  localparam int size_width_lp        = 3,
  localparam int cce_mem_msg_width_lp = cce_block_width_p + size_width_lp + paddr_width_p + msg_type_width_lp,
  localparam int count_width_lp       = $clog2(max_outstanding_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  input  logic                            mem_resp_yumi_i,
  output logic [count_width_lp-1:0]       outstanding_o,
  output logic [4:0]                      err_o,
  output logic                            err_any_o
);

  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int wd_width_lp  = $clog2(timeout_cycles_p + 1);
  localparam int tag_width_lp = msg_type_width_lp + paddr_width_p;

  typedef struct packed {
    logic [size_width_lp-1:0]     size;
    logic [paddr_width_p-1:0]     addr;
    logic [msg_type_width_lp-1:0] msg_type;
  } mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    mem_header_s                  header;
  } mem_msg_s;

`ifndef SYNTHESIS
  if (max_outstanding_p < 1) begin : g_bad_depth
    $fatal(1, "bp_nonsynth_mem_if_tracker: max_outstanding_p must be >= 1");
  end
  if (timeout_cycles_p < 1) begin : g_bad_timeout
    $fatal(1, "bp_nonsynth_mem_if_tracker: timeout_cycles_p must be >= 1");
  end
`endif

  mem_msg_s cmd_msg, resp_msg;
  logic [tag_width_lp-1:0] cmd_tag, resp_tag, head_tag;

  assign cmd_msg  = mem_msg_s'(mem_cmd_i);
  assign resp_msg = mem_msg_s'(mem_resp_i);
  assign cmd_tag  = {cmd_msg.header.msg_type, cmd_msg.header.addr};
  assign resp_tag = {resp_msg.header.msg_type, resp_msg.header.addr};

  logic [tag_width_lp-1:0]         fifo_q [max_outstanding_p];
  logic [ptr_width_lp-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [count_width_lp-1:0]       count_q, count_d;
  logic [wd_width_lp-1:0]          wd_q, wd_d;
  logic [4:0]                      err_q, err_d;
  logic                            pcmd_v_q, pcmd_rdy_q, presp_v_q, presp_yumi_q;
  logic [cce_mem_msg_width_lp-1:0] pcmd_q, presp_q;

  logic cmd_fire, resp_fire, empty, full, push, pop;
  logic ovf, unf, mism, tmo, proto;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    if (p == ptr_width_lp'(max_outstanding_p - 1)) return '0;
    return p + ptr_width_lp'(1);
  endfunction

  assign head_tag = fifo_q[rd_ptr_q];

  always_comb begin
    cmd_fire  = mem_cmd_v_i & mem_cmd_ready_i;
    resp_fire = mem_resp_v_i & mem_resp_yumi_i;
    empty     = (count_q == '0);
    full      = (count_q == count_width_lp'(max_outstanding_p));

    // A same-cycle pop frees a slot, so a push into a full FIFO is legal then.
    pop  = resp_fire & ~empty;
    push = cmd_fire & (~full | pop);
    ovf  = cmd_fire & full & ~pop;
    unf  = resp_fire & empty;
    mism = pop & (head_tag != resp_tag);

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + count_width_lp'(push) - count_width_lp'(pop);

    wd_d = wd_q;
    if (resp_fire || empty) wd_d = '0;
    else if (wd_q != wd_width_lp'(timeout_cycles_p)) wd_d = wd_q + wd_width_lp'(1);
    tmo = (wd_d == wd_width_lp'(timeout_cycles_p));

    proto = 1'b0;
    if (pcmd_v_q && !pcmd_rdy_q && (!mem_cmd_v_i || (mem_cmd_i != pcmd_q)))       proto = 1'b1;
    if (presp_v_q && !presp_yumi_q && (!mem_resp_v_i || (mem_resp_i != presp_q))) proto = 1'b1;
    if (mem_resp_yumi_i && !mem_resp_v_i)                                         proto = 1'b1;

    err_d = err_q | {proto, tmo, mism, unf, ovf};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < max_outstanding_p; i++) fifo_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wd_q         <= '0;
      err_q        <= '0;
      pcmd_v_q     <= 1'b0;
      pcmd_rdy_q   <= 1'b0;
      pcmd_q       <= '0;
      presp_v_q    <= 1'b0;
      presp_yumi_q <= 1'b0;
      presp_q      <= '0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= cmd_tag;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      pcmd_v_q     <= mem_cmd_v_i;
      pcmd_rdy_q   <= mem_cmd_ready_i;
      pcmd_q       <= mem_cmd_i;
      presp_v_q    <= mem_resp_v_i;
      presp_yumi_q <= mem_resp_yumi_i;
      presp_q      <= mem_resp_i;
    end
  end

`ifndef SYNTHESIS
  // Report only the first rising of each sticky bit.
  always_ff @(posedge clk_i) begin
    if (report_p && reset_n_i) begin
      if (err_d[0] && !err_q[0]) $error("[%0t] mem_if_tracker overflow tag=%h", $time, cmd_tag);
      if (err_d[1] && !err_q[1]) $error("[%0t] mem_if_tracker underflow tag=%h", $time, resp_tag);
      if (err_d[2] && !err_q[2]) $error("[%0t] mem_if_tracker mismatch tag=%h head=%h", $time, resp_tag, head_tag);
      if (err_d[3] && !err_q[3]) $error("[%0t] mem_if_tracker timeout tag=%h", $time, head_tag);
      if (err_d[4] && !err_q[4]) $error("[%0t] mem_if_tracker protocol tag=%h", $time, cmd_tag);
    end
  end
`endif

  assign outstanding_o = count_q;
  assign err_o         = err_q;
  assign err_any_o     = |err_q;

endmodule

// File: tb/tb_bp_nonsynth_mem_if_tracker.sv
// Directed plus randomized checks of the mem interface tracker against a queue-based model.
module tb_bp_nonsynth_mem_if_tracker;
  localparam int PADDR = 40;
  localparam int BLK   = 64;
  localparam int DEPTH = 8;
  localparam int TO    = 16;
  localparam int MSGW  = BLK + 3 + PADDR + 4;
  localparam int TAGW  = 4 + PADDR;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [MSGW-1:0] cmd = '0, resp = '0;
  logic            cmd_v = 1'b0, cmd_rdy = 1'b0, resp_v = 1'b0, yumi = 1'b0;
  logic [3:0]      outstanding;
  logic [4:0]      err;
  logic            err_any;

  int n_assert = 0;
  int n_fail   = 0;

  logic [TAGW-1:0] q[$];
  logic [4:0]      m_err = '0;
  int              m_wd = 0;
  logic            p_cmd_v = 0, p_cmd_r = 0, p_resp_v = 0, p_yumi = 0;
  logic [MSGW-1:0] p_cmd = '0, p_resp = '0;

  bp_nonsynth_mem_if_tracker #(
    .paddr_width_p(PADDR), .cce_block_width_p(BLK),
    .max_outstanding_p(DEPTH), .timeout_cycles_p(TO), .report_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_ready_i(cmd_rdy),
    .mem_resp_i(resp), .mem_resp_v_i(resp_v), .mem_resp_yumi_i(yumi),
    .outstanding_o(outstanding), .err_o(err), .err_any_o(err_any)
  );

  always #5 clk = ~clk;

  function automatic logic [MSGW-1:0] mk(input logic [3:0] t, input logic [39:0] a);
    logic [BLK-1:0] d;
    d = {$urandom, $urandom};
    return {d, 3'd6, a, t};
  endfunction

  function automatic logic [TAGW-1:0] tag_of(input logic [MSGW-1:0] m);
    return {m[3:0], m[43:4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cmd_v = 0; cmd_rdy = 0; resp_v = 0; yumi = 0;
  endtask

  // Model one clock edge from the spec's rules, then compare registered outputs.
  task automatic tick();
    logic cf, rf;
    logic [TAGW-1:0] head;
    logic [4:0] e;
    int sz0;
    cf = cmd_v & cmd_rdy;
    rf = resp_v & yumi;
    sz0 = q.size();
    e = m_err;
    if (rf) begin
      if (q.size() == 0) e[1] = 1'b1;
      else begin
        head = q.pop_front();
        if (head != tag_of(resp)) e[2] = 1'b1;
      end
    end
    if (cf) begin
      if (q.size() >= DEPTH) e[0] = 1'b1;
      else q.push_back(tag_of(cmd));
    end
    if (rf || sz0 == 0) m_wd = 0;
    else if (m_wd < TO) m_wd++;
    if (m_wd == TO) e[3] = 1'b1;
    if (p_cmd_v && !p_cmd_r && (!cmd_v || cmd !== p_cmd)) e[4] = 1'b1;
    if (p_resp_v && !p_yumi && (!resp_v || resp !== p_resp)) e[4] = 1'b1;
    if (yumi && !resp_v) e[4] = 1'b1;
    p_cmd_v = cmd_v; p_cmd_r = cmd_rdy; p_cmd = cmd;
    p_resp_v = resp_v; p_yumi = yumi; p_resp = resp;
    m_err = e;
    @(posedge clk); #1;
    chk("outstanding", 32'(outstanding), 32'(q.size()));
    chk("err", 32'(err), 32'(m_err));
    chk("err_any", 32'(err_any), 32'(|m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_any", 32'(err_any), 32'd0);
    q.delete();
    m_err = '0; m_wd = 0;
    p_cmd_v = 0; p_cmd_r = 0; p_resp_v = 0; p_yumi = 0; p_cmd = '0; p_resp = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [3:0] t, input logic [39:0] a);
    cmd = mk(t, a); cmd_v = 1; cmd_rdy = 1; resp_v = 0; yumi = 0;
    tick();
  endtask

  task automatic send_resp(input logic [3:0] t, input logic [39:0] a);
    resp = mk(t, a); resp_v = 1; yumi = 1; cmd_v = 0; cmd_rdy = 0;
    tick();
  endtask

  initial begin
    logic [39:0] addrs [3];
    logic [3:0]  t;
    logic [39:0] a;
    addrs[0] = 40'h100; addrs[1] = 40'h140; addrs[2] = 40'h180;

    // 1: three reads then in-order responses
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_cmd(4'd0, addrs[i]);
      chk("t1_out_up", 32'(outstanding), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      send_resp(4'd0, addrs[i]);
      chk("t1_out_dn", 32'(outstanding), 32'(2 - i));
    end
    chk("t1_err", 32'(err), 32'd0);

    // 2: overflow on the ninth command
    do_reset();
    for (int i = 0; i < 9; i++) send_cmd(4'd0, 40'(i * 64));
    chk("t2_err", 32'(err), 32'h01);
    chk("t2_out", 32'(outstanding), 32'd8);
    // full FIFO with simultaneous push and pop keeps the count
    cmd = mk(4'd1, 40'h3c0); cmd_v = 1; cmd_rdy = 1;
    resp = mk(4'd0, 40'h000); resp_v = 1; yumi = 1;
    tick();
    chk("t2_full_pushpop", 32'(outstanding), 32'd8);
    chk("t2_err_after", 32'(err), 32'h01);

    // 3: response with nothing outstanding
    do_reset();
    send_resp(4'd0, 40'h100);
    chk("t3_err", 32'(err), 32'h02);
    chk("t3_out", 32'(outstanding), 32'd0);

    // 4: address mismatch
    do_reset();
    send_cmd(4'd0, 40'h200);
    send_resp(4'd0, 40'h240);
    chk("t4_err", 32'(err), 32'h04);
    chk("t4_out", 32'(outstanding), 32'd0);

    // 5: watchdog fires on the 16th cycle after the fire
    do_reset();
    send_cmd(4'd0, 40'h300);
    idle();
    for (int i = 0; i < 15; i++) tick();
    chk("t5_no_tmo_yet", 32'(err), 32'h00);
    tick();
    chk("t5_tmo", 32'(err), 32'h08);
    do_reset();
    send_cmd(4'd0, 40'h300);
    idle();
    for (int i = 0; i < 14; i++) tick();
    send_resp(4'd0, 40'h300);
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("t5_resp_in_time", 32'(err), 32'h00);

    // 6: command changed while stalled, then asynchronous reset
    do_reset();
    cmd = mk(4'd0, 40'h400); cmd_v = 1; cmd_rdy = 0;
    tick();
    cmd = mk(4'd0, 40'h440);
    tick();
    chk("t6_proto", 32'(err), 32'h10);
    #2;
    do_reset();

    // randomized traffic, mostly protocol-legal, reset periodically to re-arm sticky bits
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        if (p_cmd_v && !p_cmd_r && $urandom_range(0, 99) != 0) begin
          cmd_v = 1;
        end else begin
          cmd_v = 1'($urandom_range(0, 1));
          t = 4'($urandom_range(0, 3));
          a = 40'($urandom_range(0, 7) * 64);
          cmd = mk(t, a);
        end
        cmd_rdy = ($urandom_range(0, 3) != 0);
        if (p_resp_v && !p_yumi && $urandom_range(0, 99) != 0) begin
          resp_v = 1;
        end else begin
          resp_v = 1'($urandom_range(0, 1));
          if (q.size() > 0 && $urandom_range(0, 9) != 0) resp = {64'($urandom), 3'd6, q[0][39:0], q[0][43:40]};
          else resp = mk(4'($urandom_range(0, 3)), 40'($urandom_range(0, 7) * 64));
        end
        yumi = resp_v ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end
endmodule
